// File: rtl/i2s_sample_scheduler_if.sv
// Source-side handshake and I2S-side output bundle of the sample scheduler.
// master = sources/transmitter side, slave = scheduler.
interface i2s_sample_scheduler_if #(
  parameter int DAC_OUTPUT_WIDTH = 24,
  parameter int NUM_SRC          = 2,
  parameter int FIFO_DEPTH       = 4
);
  localparam int W = DAC_OUTPUT_WIDTH;

  logic [NUM_SRC-1:0]            src_enable;
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC*W-1:0]          src_left;
  logic [NUM_SRC*W-1:0]          src_right;
  logic                          sample_valid;
  logic [W-1:0]                  left_channel;
  logic [W-1:0]                  right_channel;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic [7:0]                    underrun_count;

  modport master (
    output src_enable, src_valid, src_left, src_right,
    input  src_ready, sample_valid, left_channel, right_channel, fifo_level, underrun_count
  );

  modport slave (
    input  src_enable, src_valid, src_left, src_right,
    output src_ready, sample_valid, left_channel, right_channel, fifo_level, underrun_count
  );
endinterface

// File: rtl/i2s_sample_scheduler.sv
// Gathers one stereo sample per enabled source each frame, mixes with saturation into a FIFO,
// and strobes one frame per sample period. Build macro: I2S_SCHED_UNDERRUN_ZERO_EN.
module i2s_sample_scheduler #(
  parameter int DAC_OUTPUT_WIDTH = 24,
  parameter int NUM_SRC          = 2,
  parameter int FIFO_DEPTH       = 4,
  parameter int SAMPLE_DIV       = 512
) (
  input  logic                 clk,
  input  logic                 reset_n,
  i2s_sample_scheduler_if.slave bus_if
);
  localparam int W  = DAC_OUTPUT_WIDTH;
  localparam int AW = W + $clog2(NUM_SRC) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {IDLE, GATHER, SUM, PUSH} state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] frame_mask_q, captured_q, ready, take;
  logic [AW-1:0]      acc_l_q, acc_r_q, add_l, add_r;
  logic [W-1:0]       sat_l_q, sat_r_q;
  logic [CW-1:0]      cnt_q;
  logic               tick;
  logic [2*W-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        count_q;
  logic               full, empty, push, pop;
  logic               sample_valid_q;
  logic [W-1:0]       left_q, right_q;
  logic [7:0]         underrun_q;

  function automatic logic [AW-1:0] sext(input logic [W-1:0] s);
    return {{(AW-W){s[W-1]}}, s};
  endfunction

  // In range when every bit above the sign position agrees with it.
  function automatic logic [W-1:0] sat(input logic [AW-1:0] a);
    if ((a[AW-1:W-1] == '0) || (a[AW-1:W-1] == {(AW-W+1){1'b1}})) return a[W-1:0];
    else if (a[AW-1]) return {1'b1, {(W-1){1'b0}}};
    else return {1'b0, {(W-1){1'b1}}};
  endfunction

  assign tick  = (cnt_q == CW'(SAMPLE_DIV - 1));
  assign ready = (state_q == GATHER) ? (frame_mask_q & ~captured_q) : '0;
  assign take  = bus_if.src_valid & ready;
  assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = (state_q == PUSH) && !full;
  assign pop   = tick && !empty;

  always_comb begin
    add_l = '0;
    add_r = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (take[i]) begin
        add_l = add_l + sext(bus_if.src_left[i*W +: W]);
        add_r = add_r + sext(bus_if.src_right[i*W +: W]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      frame_mask_q <= '0;
      captured_q   <= '0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      sat_l_q      <= '0;
      sat_r_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_mask_q <= bus_if.src_enable;
          captured_q   <= '0;
          acc_l_q      <= '0;
          acc_r_q      <= '0;
          state_q      <= GATHER;
        end
        GATHER: begin
          captured_q <= captured_q | take;
          acc_l_q    <= acc_l_q + add_l;
          acc_r_q    <= acc_r_q + add_r;
          if ((captured_q | take) == frame_mask_q) state_q <= SUM;
        end
        SUM: begin
          sat_l_q <= sat(acc_l_q);
          sat_r_q <= sat(acc_r_q);
          state_q <= PUSH;
        end
        PUSH: begin
          if (!full) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {sat_l_q, sat_r_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + (PW+1)'(1);
      else if (pop && !push) count_q <= count_q - (PW+1)'(1);
    end
  end

  // The strobe fires every period; an empty FIFO only changes what data goes with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_valid_q <= 1'b0;
      left_q         <= '0;
      right_q        <= '0;
      underrun_q     <= '0;
    end else begin
      sample_valid_q <= tick;
      if (tick) begin
        if (!empty) begin
          {left_q, right_q} <= mem_q[rd_ptr_q];
        end else begin
          if (underrun_q != 8'hFF) underrun_q <= underrun_q + 8'd1;
`ifdef I2S_SCHED_UNDERRUN_ZERO_EN
          left_q  <= '0;
          right_q <= '0;
`else
          left_q  <= left_q;
          right_q <= right_q;
`endif
        end
      end
    end
  end

  assign bus_if.src_ready      = ready;
  assign bus_if.sample_valid   = sample_valid_q;
  assign bus_if.left_channel   = left_q;
  assign bus_if.right_channel  = right_q;
  assign bus_if.fifo_level     = count_q;
  assign bus_if.underrun_count = underrun_q;
endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Directed phases with randomized source data and valid timing, checked against a
// frame-level mixing model (frame k = saturated sum of each enabled source's k-th sample).
module tb_i2s_sample_scheduler;
  localparam int W = 24, NS = 2, DEPTH = 4, DIV = 512, NF = 64;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  i2s_sample_scheduler_if #(.DAC_OUTPUT_WIDTH(W), .NUM_SRC(NS), .FIFO_DEPTH(DEPTH)) bus();

  i2s_sample_scheduler #(
    .DAC_OUTPUT_WIDTH(W), .NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .SAMPLE_DIV(DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus_if(bus)
  );

  int vectors = 0, miscompares = 0;
  logic [W-1:0] sl [NS][NF];
  logic [W-1:0] sr [NS][NF];
  int idx [NS], lim [NS], base [NS];
  logic [NS-1:0] vld, hs, mask;
  int prob, cyc, strobe_n, navail, first_cyc, ur_model;
  logic [W-1:0] last_l, last_r;
  bit bp_chk, pend4, prev_sv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mix(input int k, input bit right);
    int s;
    int j;
    logic [31:0] t;
    s = 0;
    for (int i = 0; i < NS; i++) begin
      if (mask[i]) begin
        j = base[i] + k;
        if (j < NF) s += right ? int'($signed(sr[i][j])) : int'($signed(sl[i][j]));
      end
    end
    if (s > 8388607) return 24'h7FFFFF;
    if (s < -8388608) return 24'h800000;
    t = s;
    return t[W-1:0];
  endfunction

  task automatic drive();
    int j;
    bus.src_valid = vld;
    for (int i = 0; i < NS; i++) begin
      j = (idx[i] < NF) ? idx[i] : NF - 1;
      bus.src_left[i*W +: W]  = sl[i][j];
      bus.src_right[i*W +: W] = sr[i][j];
    end
  endtask

  task automatic model_restart();
    strobe_n = 0; ur_model = 0; last_l = '0; last_r = '0;
    navail = 1000; pend4 = 0; prev_sv = 0; first_cyc = -1; cyc = 0;
  endtask

  task automatic step();
    logic [W-1:0] el, er;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) idx[i]++;
      if (hs[i] || !vld[i]) vld[i] = (idx[i] < lim[i]) && ($urandom_range(0, 99) < prob);
    end
    drive();
    #1;
    hs = vld & bus.src_ready;
    if (bus.sample_valid === 1'b1) begin
      chk("strobe_width", 32'(prev_sv), 0);
      if (strobe_n == 0) first_cyc = cyc;
      if (strobe_n < navail) begin
        el = mix(strobe_n, 1'b0); er = mix(strobe_n, 1'b1);
        last_l = el; last_r = er;
      end else begin
        if (ur_model < 255) ur_model++;
`ifdef I2S_SCHED_UNDERRUN_ZERO_EN
        el = '0; er = '0;
`else
        el = last_l; er = last_r;
`endif
      end
      chk("left_channel", 32'(bus.left_channel), 32'(el));
      chk("right_channel", 32'(bus.right_channel), 32'(er));
      chk("underrun_count", 32'(bus.underrun_count), ur_model);
      strobe_n++;
      if (bp_chk) begin
        chk("bp_level_after_pop", 32'(bus.fifo_level), 3);
        pend4 = 1;
      end
    end else if (pend4) begin
      chk("bp_level_refill", 32'(bus.fifo_level), 4);
      pend4 = 0;
    end
    if (bp_chk && (cyc % DIV == DIV - 1)) begin
      chk("bp_level_full", 32'(bus.fifo_level), 4);
      chk("bp_ready_low", 32'(bus.src_ready), 0);
    end
    prev_sv = bus.sample_valid;
  endtask

  task automatic assert_reset(input logic [NS-1:0] m, input int p);
    @(negedge clk);
    #2 reset_n = 1'b0;
    mask = m; prob = p; bus.src_enable = m;
    vld = '0; hs = '0; bp_chk = 0;
    for (int i = 0; i < NS; i++) begin
      idx[i] = 0; base[i] = 0; lim[i] = NF;
      for (int k = 0; k < NF; k++) begin
        sl[i][k] = W'($urandom);
        sr[i][k] = W'($urandom);
      end
    end
    model_restart();
    drive();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_restart();
  endtask

  task automatic run_strobes(input int n, input string tag);
    int budget;
    budget = n * DIV + DIV;
    while (strobe_n < n && budget > 0) begin
      step();
      budget--;
    end
    chk({tag, "_strobes_reached"}, 32'(strobe_n >= n), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    reset_n = 1'b1;
    bus.src_enable = '0; bus.src_valid = '0; bus.src_left = '0; bus.src_right = '0;
    vld = '0; hs = '0;

    // Phase 1: no sources enabled -> silence frames, strobe timing, reset values.
    assert_reset(2'b00, 0);
    #1;
    chk("rst_sample_valid", 32'(bus.sample_valid), 0);
    chk("rst_left", 32'(bus.left_channel), 0);
    chk("rst_right", 32'(bus.right_channel), 0);
    chk("rst_fifo_level", 32'(bus.fifo_level), 0);
    chk("rst_underrun", 32'(bus.underrun_count), 0);
    chk("rst_src_ready", 32'(bus.src_ready), 0);
    release_reset();
    bp_chk = 1;
    run_strobes(3, "silence");
    chk("first_strobe_cycle", 32'(first_cyc), DIV);

    // Phase 2: both sources always valid; directed sum and saturation, then back-pressure.
    assert_reset(2'b11, 100);
    sl[0][0] = 24'h100000; sr[0][0] = 24'h000010;
    sl[1][0] = 24'h200000; sr[1][0] = 24'hFFFFF0;
    sl[0][1] = 24'h7FFFFF; sr[0][1] = 24'h800000;
    sl[1][1] = 24'h7FFFFF; sr[1][1] = 24'h800000;
    release_reset();
    step();
    chk("both_ready_same_cycle", 32'(bus.src_ready), 32'h3);
    chk("both_handshake", 32'(hs), 32'h3);
    step();
    step();
    chk("level_before_write", 32'(bus.fifo_level), 0);
    step();
    chk("level_after_write", 32'(bus.fifo_level), 1);
    bp_chk = 1;
    run_strobes(6, "backpressure");

    // Phase 3: random enable pattern and bursty valids.
    assert_reset(2'($urandom_range(1, 3)), 40);
    release_reset();
    run_strobes(5, "random_mix");

    // Phase 4: source 1 runs dry after 3 samples -> FIFO drains, then underruns.
    assert_reset(2'b11, 70);
    lim[1] = 3;
    navail = 3;
    release_reset();
    navail = 3;
    run_strobes(6, "stall");
    chk("stall_ready", 32'(bus.src_ready), 32'h1 << 1);
    chk("stall_src0_captures", 32'(idx[0]), 4);
    chk("stall_src1_captures", 32'(idx[1]), 3);
    chk("stall_underruns", 32'(bus.underrun_count), 3);

    // Phase 5: async reset while source 0 is captured mid-frame.
    assert_reset(2'b11, 100);
    lim[1] = 2;
    sl[0][2] = 24'h111111; sr[0][2] = 24'h222222;
    release_reset();
    run_strobes(1, "pre_reset");
    budget = 50;
    while (idx[0] < 3 && budget > 0) begin
      step();
      budget--;
    end
    chk("pre_rst_src0_captured", 32'(idx[0]), 3);
    chk("pre_rst_ready", 32'(bus.src_ready), 32'h1 << 1);
    chk("pre_rst_level", 32'(bus.fifo_level), 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.src_ready), 0);
    chk("midrst_level", 32'(bus.fifo_level), 0);
    chk("midrst_valid", 32'(bus.sample_valid), 0);
    chk("midrst_left", 32'(bus.left_channel), 0);
    chk("midrst_right", 32'(bus.right_channel), 0);
    hs = '0;
    lim[1] = NF;
    release_reset();
    for (int i = 0; i < NS; i++) base[i] = idx[i];
    run_strobes(1, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
